// File: rtl/gate_seq_fsm_if.sv
// gate_seq_pkg / gate_seq_if
//
// Purpose: This file holds the complex-number field type and the bundled
// handshake and data signals of the gate sequencer.
//
// Each complex number has two fields, a and b. Both are Q2.14.
//
// Signals in the interface (directions are as seen by the sequencer, i.e. the slave):
//   init_valid  in   initial state vector offered
//   init_ready  out  sequencer accepts an initial vector (IDLE only)
//   init_state  in   initial vector, L entries
//   gate_valid  in   gate matrix offered
//   gate_ready  out  sequencer accepts a gate (READY only)
//   gate_last   in   marks the final gate of a sequence
//   gate_in     in   gate matrix, [row][col], L x L entries
//   mult_state  out  held vector, feeds the external multiplier
//   mult_gate   out  held gate, feeds the external multiplier
//   mult_result in   multiplier product vector
//   out_state   out  current vector (same register as mult_state)
//   busy        out  high while a gate is being applied
//   done        out  one-cycle pulse when a sequence completes
//   gate_count  out  captures since last init load (only with GATE_SEQ_COUNT_EN)
//
// Optional feature macro: GATE_SEQ_COUNT_EN

package gate_seq_pkg;
  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } complex_num_t;
endpackage

interface gate_seq_if #(
  parameter int N = 2
);
  import gate_seq_pkg::*;

  localparam int L = 2 ** N;

  logic                            init_valid;
  logic                            init_ready;
  complex_num_t [L-1:0]            init_state;
  logic                            gate_valid;
  logic                            gate_ready;
  logic                            gate_last;
  complex_num_t [L-1:0][L-1:0]     gate_in;
  complex_num_t [L-1:0]            mult_state;
  complex_num_t [L-1:0][L-1:0]     mult_gate;
  complex_num_t [L-1:0]            mult_result;
  complex_num_t [L-1:0]            out_state;
  logic                            busy;
  logic                            done;
`ifdef GATE_SEQ_COUNT_EN
  logic [15:0]                     gate_count;
`endif

`ifdef GATE_SEQ_COUNT_EN
  modport slave (
    input  init_valid, init_state, gate_valid, gate_last, gate_in, mult_result,
    output init_ready, gate_ready, mult_state, mult_gate, out_state, busy, done,
           gate_count
  );

  modport master (
    output init_valid, init_state, gate_valid, gate_last, gate_in, mult_result,
    input  init_ready, gate_ready, mult_state, mult_gate, out_state, busy, done,
           gate_count
  );
`else
  modport slave (
    input  init_valid, init_state, gate_valid, gate_last, gate_in, mult_result,
    output init_ready, gate_ready, mult_state, mult_gate, out_state, busy, done
  );

  modport master (
    output init_valid, init_state, gate_valid, gate_last, gate_in, mult_result,
    input  init_ready, gate_ready, mult_state, mult_gate, out_state, busy, done
  );
`endif

endinterface

// File: rtl/gate_seq_fsm.sv
// gate_seq_fsm
//
// Purpose: This block sequences quantum gates over an external combinational
// matrix-vector multiplier.
//
// Operation:
//   1. An initial state vector is loaded in IDLE.
//   2. Gates are accepted one at a time in READY.
//   3. For each gate, the block waits SETTLE cycles in APPLY while the
//      multiplier settles. It then captures the product back into the state
//      register.
//   4. After the gate flagged gate_last, the block pulses done once and
//      returns to IDLE.
//
// The block performs no arithmetic on vector data. Fields are stored and
// forwarded bit-exact.
//
// Parameters:
//   N       qubit count. The vector length is L = 2**N and a gate is L x L.
//   SETTLE  number of multiplier settle cycles. The legal range is 1..15.
//
// Ports:
//   clk     single clock. All state changes happen on its rising edge.
//   reset   synchronous, active-high. It returns the block to IDLE and
//           clears every register.
//   bus     gate_seq_if.slave. This carries the handshakes, the vectors, the
//           gate, busy and done.
//
// Optional feature (macro GATE_SEQ_COUNT_EN):
//   Adds bus.gate_count, a 16-bit saturating count of captures since the last
//   init load. It is cleared by reset and by an init load.
//
// States:
//   state  | meaning
//   IDLE   | waiting for an initial vector (init_ready=1)
//   READY  | vector held, waiting for a gate (gate_ready=1)
//   APPLY  | gate held, multiplier settling (busy=1); captures on last cycle
//   DONE   | sequence finished, done pulses for one cycle

module gate_seq_fsm #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       reset,
  gate_seq_if.slave  bus
);
  import gate_seq_pkg::*;

  localparam int L = 2 ** N;

  // The settle counter counts up from zero. Capture happens on the edge
  // where it equals SETTLE-1, so APPLY lasts exactly SETTLE cycles.
  localparam logic [3:0] SETTLE_TC = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_APPLY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  complex_num_t [L-1:0]          vec_q, vec_d;
  complex_num_t [L-1:0][L-1:0]   gate_q, gate_d;
  logic [3:0]                    settle_q, settle_d;
  logic                          last_q, last_d;

  logic                          init_ready;
  logic                          gate_ready;
  logic                          busy;
  logic                          done;
  logic                          load_init;
  logic                          capture;

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    gate_d     = gate_q;
    settle_d   = settle_q;
    last_d     = last_q;
    init_ready = 1'b0;
    gate_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load_init  = 1'b0;
    capture    = 1'b0;

    case (state_q)
      S_IDLE: begin
        init_ready = 1'b1;
        if (bus.init_valid) begin
          load_init = 1'b1;
          vec_d     = bus.init_state;
          state_d   = S_READY;
        end
      end

      S_READY: begin
        gate_ready = 1'b1;
        if (bus.gate_valid) begin
          gate_d   = bus.gate_in;
          last_d   = bus.gate_last;
          settle_d = 4'd0;
          state_d  = S_APPLY;
        end
      end

      S_APPLY: begin
        busy     = 1'b1;
        settle_d = settle_q + 4'd1;
        if (settle_q == SETTLE_TC) begin
          // The product is only trusted after SETTLE cycles. Product values
          // from earlier cycles never reach the state register.
          capture = 1'b1;
          vec_d   = bus.mult_result;
          state_d = last_q ? S_DONE : S_READY;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. A reset edge overrides any capture or load
  // that the decode above would otherwise perform.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      gate_q   <= '0;
      settle_q <= 4'd0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      gate_q   <= gate_d;
      settle_q <= settle_d;
      last_q   <= last_d;
    end
  end

`ifdef GATE_SEQ_COUNT_EN
  logic [15:0] gate_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gate_count_q <= 16'd0;
    end else if (load_init) begin
      gate_count_q <= 16'd0;
    end else if (capture && (gate_count_q != 16'hFFFF)) begin
      gate_count_q <= gate_count_q + 16'd1;
    end
  end

  assign bus.gate_count = gate_count_q;
`else
  // load_init only feeds the optional capture counter.
  logic unused_load_init;
  assign unused_load_init = load_init;
`endif

  assign bus.init_ready = init_ready;
  assign bus.gate_ready = gate_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.mult_state = vec_q;
  assign bus.out_state  = vec_q;
  assign bus.mult_gate  = gate_q;

endmodule

// File: tb/tb_gate_seq_fsm.sv
module tb_gate_seq_fsm;
  import gate_seq_pkg::*;

  typedef complex_num_t [3:0]      vec_t;
  typedef complex_num_t [3:0][3:0] gmat_t;

  typedef struct {
    vec_t vec;
    int   lat;
    int   cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a, reset_b;
  always #5 clk = ~clk;

  gate_seq_if #(.N(2)) bus_a ();
  gate_seq_if #(.N(2)) bus_b ();

  gate_seq_fsm #(.N(2), .SETTLE(1)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  gate_seq_fsm #(.N(2), .SETTLE(3)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  exp_t cap_q_a[$], done_q_a[$], cap_q_b[$], done_q_b[$];
  int   done_cnt_a = 0, done_cnt_b = 0;
  int   exp_done_a = 0, exp_done_b = 0;

  function automatic vec_t mkv(logic [15:0] a0, logic [15:0] a1,
                               logic [15:0] a2, logic [15:0] a3);
    vec_t v;
    v[0] = '{a: a0, b: 16'h0};
    v[1] = '{a: a1, b: 16'h0};
    v[2] = '{a: a2, b: 16'h0};
    v[3] = '{a: a3, b: 16'h0};
    return v;
  endfunction

  function automatic vec_t fillv(logic [15:0] a, logic [15:0] b);
    vec_t v;
    for (int i = 0; i < 4; i++) v[i] = '{a: a, b: b};
    return v;
  endfunction

  function automatic gmat_t diag(logic [15:0] d);
    gmat_t g;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        g[i][j] = (i == j) ? '{a: d, b: 16'h0} : '{a: 16'h0, b: 16'h0};
    return g;
  endfunction

  function automatic gmat_t swap_pairs();
    gmat_t g;
    g = '0;
    g[0][1].a = 16'h4000;
    g[1][0].a = 16'h4000;
    g[2][3].a = 16'h4000;
    g[3][2].a = 16'h4000;
    return g;
  endfunction

  function automatic gmat_t fillg(logic [15:0] a);
    gmat_t g;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        g[i][j] = '{a: a, b: a};
    return g;
  endfunction

  // Reference Q2.14 complex matrix-vector product standing in for the multiplier
  function automatic vec_t matvec(gmat_t g, vec_t s);
    vec_t r;
    for (int i = 0; i < 4; i++) begin
      int ar, ai;
      ar = 0;
      ai = 0;
      for (int j = 0; j < 4; j++) begin
        int ga, gb, sa, sb;
        ga = int'($signed(g[i][j].a));
        gb = int'($signed(g[i][j].b));
        sa = int'($signed(s[j].a));
        sb = int'($signed(s[j].b));
        ar += ga * sa - gb * sb;
        ai += ga * sb + gb * sa;
      end
      r[i].a = 16'(ar >>> 14);
      r[i].b = 16'(ai >>> 14);
    end
    return r;
  endfunction

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: condition not met within cycle budget", name);
  endtask

  // DUT A: the multiplier model
  always_comb bus_a.mult_result = matvec(bus_a.mult_gate, bus_a.mult_state);

  // DUT B: the product is only valid on the third APPLY cycle
  int b_cyc = 0;
  initial begin
    bus_b.mult_result = fillv(16'h7777, 16'h7777);
    forever begin
      @(negedge clk);
      if (bus_b.busy) b_cyc = b_cyc + 1;
      else            b_cyc = 0;
      bus_b.mult_result = (b_cyc == 3) ? fillv(16'h1234, 16'h0ABC)
                                       : fillv(16'h7777, 16'h7777);
    end
  end

  // Sample reset as seen at each active edge
  logic rst_edge_a = 1'b1, rst_edge_b = 1'b1;
  initial forever begin
    @(posedge clk);
    rst_edge_a = reset_a;
    rst_edge_b = reset_b;
  end

  // Scoreboard monitor, DUT A
  initial begin
    logic busy_prev, done_prev;
    int   run;
    exp_t e;
    busy_prev = 1'b0;
    done_prev = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus_a.busy) run++;
      if (busy_prev && !bus_a.busy && !rst_edge_a) begin
        if (cap_q_a.size() == 0) begin
          fail_now("a_unexpected_capture");
        end else begin
          e = cap_q_a.pop_front();
          chk("a_capture_state", bus_a.out_state, e.vec);
          chk("a_capture_latency", run, e.lat);
        end
      end
      if (!bus_a.busy) run = 0;
      if (bus_a.done) begin
        done_cnt_a++;
        chk("a_done_width", done_prev, 1'b0);
        if (done_q_a.size() == 0) begin
          fail_now("a_unexpected_done");
        end else begin
          e = done_q_a.pop_front();
          chk("a_done_state", bus_a.out_state, e.vec);
`ifdef GATE_SEQ_COUNT_EN
          chk("a_done_gate_count", bus_a.gate_count, e.cnt);
`endif
        end
      end
      busy_prev = bus_a.busy;
      done_prev = bus_a.done;
    end
  end

  // Scoreboard monitor, DUT B
  initial begin
    logic busy_prev, done_prev;
    int   run;
    exp_t e;
    busy_prev = 1'b0;
    done_prev = 1'b0;
    run = 0;
    forever begin
      @(negedge clk);
      if (bus_b.busy) run++;
      if (busy_prev && !bus_b.busy && !rst_edge_b) begin
        if (cap_q_b.size() == 0) begin
          fail_now("b_unexpected_capture");
        end else begin
          e = cap_q_b.pop_front();
          chk("b_capture_state", bus_b.out_state, e.vec);
          chk("b_capture_latency", run, e.lat);
        end
      end
      if (!bus_b.busy) run = 0;
      if (bus_b.done) begin
        done_cnt_b++;
        chk("b_done_width", done_prev, 1'b0);
        if (done_q_b.size() == 0) begin
          fail_now("b_unexpected_done");
        end else begin
          e = done_q_b.pop_front();
          chk("b_done_state", bus_b.out_state, e.vec);
`ifdef GATE_SEQ_COUNT_EN
          chk("b_done_gate_count", bus_b.gate_count, e.cnt);
`endif
        end
      end
      busy_prev = bus_b.busy;
      done_prev = bus_b.done;
    end
  end

  task automatic wait_idle_a(string name);
    for (int i = 0; i < 50; i++) begin
      if (bus_a.init_ready) break;
      @(posedge clk); #1;
    end
    if (!bus_a.init_ready) fail_now(name);
  endtask

  task automatic wait_idle_b(string name);
    for (int i = 0; i < 50; i++) begin
      if (bus_b.init_ready) break;
      @(posedge clk); #1;
    end
    if (!bus_b.init_ready) fail_now(name);
  endtask

  task automatic load_init_a(vec_t v);
    wait_idle_a("a_init_ready_timeout");
    bus_a.init_valid = 1'b1;
    bus_a.init_state = v;
    @(posedge clk); #1;
    bus_a.init_valid = 1'b0;
  endtask

  task automatic send_gate_a(gmat_t g, bit last, vec_t exp_vec, int cnt);
    exp_t e;
    for (int i = 0; i < 50; i++) begin
      if (bus_a.gate_ready) break;
      @(posedge clk); #1;
    end
    if (!bus_a.gate_ready) fail_now("a_gate_ready_timeout");
    e.vec = exp_vec;
    e.lat = 1;
    e.cnt = cnt;
    cap_q_a.push_back(e);
    if (last) begin
      done_q_a.push_back(e);
      exp_done_a++;
    end
    bus_a.gate_valid = 1'b1;
    bus_a.gate_in    = g;
    bus_a.gate_last  = last;
    @(posedge clk); #1;
    bus_a.gate_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    bus_a.init_valid = 1'b0; bus_a.init_state = '0;
    bus_a.gate_valid = 1'b0; bus_a.gate_last  = 1'b0; bus_a.gate_in = '0;
    bus_b.init_valid = 1'b0; bus_b.init_state = '0;
    bus_b.gate_valid = 1'b0; bus_b.gate_last  = 1'b0; bus_b.gate_in = '0;
    reset_a = 1'b1;
    reset_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_init_ready", bus_a.init_ready, 1'b1);
    chk("rst_gate_ready", bus_a.gate_ready, 1'b0);
    chk("rst_busy",       bus_a.busy,       1'b0);
    chk("rst_done",       bus_a.done,       1'b0);
    chk("rst_out_state",  bus_a.out_state,  512'h0);
    chk("rst_mult_state", bus_a.mult_state, 512'h0);
    chk("rst_mult_gate",  bus_a.mult_gate,  512'h0);
    chk("rst_b_out_state", bus_b.out_state, 512'h0);
`ifdef GATE_SEQ_COUNT_EN
    chk("rst_gate_count", bus_a.gate_count, 16'h0);
`endif
    @(posedge clk); #1;

    // Identity gate, single gate sequence
    load_init_a(mkv(16'h4000, 0, 0, 0));
    @(negedge clk);
    chk("t035_gate_ready", bus_a.gate_ready, 1'b1);
    chk("t035_init_ready", bus_a.init_ready, 1'b0);
    chk("t035_mult_state", bus_a.mult_state, mkv(16'h4000, 0, 0, 0));
    send_gate_a(diag(16'h4000), 1'b1, mkv(16'h4000, 0, 0, 0), 1);
    @(negedge clk);
    chk("t035_busy_after_accept", bus_a.busy, 1'b1);
    chk("t035_no_early_done", bus_a.done, 1'b0);
    @(negedge clk);
    chk("t035_done_after_capture", bus_a.done, 1'b1);
    wait_idle_a("t035_idle_timeout");

    // Two pair-swap gates back to back
    load_init_a(mkv(16'h4000, 0, 0, 0));
    send_gate_a(swap_pairs(), 1'b0, mkv(0, 16'h4000, 0, 0), 0);
    send_gate_a(swap_pairs(), 1'b1, mkv(16'h4000, 0, 0, 0), 2);
    wait_idle_a("t036_idle_timeout");

    // Illegal-state handshakes are ignored
    bus_a.gate_valid = 1'b1;
    bus_a.gate_in    = fillg(16'h1111);
    bus_a.gate_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t038_idle_gate_ready", bus_a.gate_ready, 1'b0);
      chk("t038_idle_mult_gate",  bus_a.mult_gate,  swap_pairs());
      chk("t038_idle_out_state",  bus_a.out_state,  mkv(16'h4000, 0, 0, 0));
      @(posedge clk); #1;
    end
    bus_a.gate_valid = 1'b0;
    load_init_a(mkv(0, 0, 16'h4000, 0));
    bus_a.init_valid = 1'b1;
    bus_a.init_state = fillv(16'h1111, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t038_ready_init_ready", bus_a.init_ready, 1'b0);
      chk("t038_ready_gate_ready", bus_a.gate_ready, 1'b1);
      chk("t038_ready_mult_state", bus_a.mult_state, mkv(0, 0, 16'h4000, 0));
      @(posedge clk); #1;
    end
    send_gate_a(diag(16'h4000), 1'b1, mkv(0, 0, 16'h4000, 0), 1);
    bus_a.init_valid = 1'b0;
    wait_idle_a("t038_idle_timeout");

`ifdef GATE_SEQ_COUNT_EN
    // Capture counter over a five-gate sequence
    load_init_a(mkv(16'h4000, 0, 0, 0));
    for (int k = 1; k <= 5; k++)
      send_gate_a(diag(16'h4000), (k == 5), mkv(16'h4000, 0, 0, 0), 5);
    wait_idle_a("t040_idle_timeout");
    chk("t040_count_in_idle", bus_a.gate_count, 16'd5);
    load_init_a(mkv(0, 16'h4000, 0, 0));
    @(negedge clk);
    chk("t040_count_cleared", bus_a.gate_count, 16'd0);
    @(posedge clk); #1;
`endif

    // SETTLE=3: only the third-cycle product is captured
    bus_b.init_valid = 1'b1;
    bus_b.init_state = fillv(16'h0101, 16'h0202);
    @(posedge clk); #1;
    bus_b.init_valid = 1'b0;
    @(negedge clk);
    chk("t037_b_gate_ready", bus_b.gate_ready, 1'b1);
    chk("t037_b_mult_state", bus_b.mult_state, fillv(16'h0101, 16'h0202));
    eb.vec = fillv(16'h1234, 16'h0ABC);
    eb.lat = 3;
    eb.cnt = 1;
    cap_q_b.push_back(eb);
    done_q_b.push_back(eb);
    exp_done_b++;
    bus_b.gate_valid = 1'b1;
    bus_b.gate_in    = diag(16'h4000);
    bus_b.gate_last  = 1'b1;
    @(posedge clk); #1;
    bus_b.gate_in    = fillg(16'h1111);
    bus_b.init_valid = 1'b1;
    bus_b.init_state = fillv(16'h5555, 16'h5555);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t037_apply_busy",       bus_b.busy,       1'b1);
      chk("t037_apply_gate_ready", bus_b.gate_ready, 1'b0);
      chk("t037_apply_init_ready", bus_b.init_ready, 1'b0);
      chk("t037_apply_mult_gate",  bus_b.mult_gate,  diag(16'h4000));
      chk("t037_apply_hold_state", bus_b.mult_state, fillv(16'h0101, 16'h0202));
      @(posedge clk); #1;
    end
    bus_b.gate_valid = 1'b0;
    bus_b.init_valid = 1'b0;
    @(negedge clk);
    chk("t037_cycle3_hold_state", bus_b.mult_state, fillv(16'h0101, 16'h0202));
    wait_idle_b("t037_idle_timeout");

    // Reset during the second APPLY cycle discards the gate
    bus_b.init_valid = 1'b1;
    bus_b.init_state = fillv(16'h0303, 16'h0404);
    @(posedge clk); #1;
    bus_b.init_valid = 1'b0;
    bus_b.gate_valid = 1'b1;
    bus_b.gate_in    = diag(16'h4000);
    bus_b.gate_last  = 1'b1;
    @(posedge clk); #1;
    bus_b.gate_valid = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
    @(negedge clk);
    chk("t039_init_ready",  bus_b.init_ready, 1'b1);
    chk("t039_gate_ready",  bus_b.gate_ready, 1'b0);
    chk("t039_busy",        bus_b.busy,       1'b0);
    chk("t039_done",        bus_b.done,       1'b0);
    chk("t039_out_state",   bus_b.out_state,  512'h0);
    chk("t039_mult_gate",   bus_b.mult_gate,  512'h0);
    repeat (6) @(posedge clk);
    #1;

    // Drain checks
    repeat (4) @(posedge clk);
    #1;
    chk("a_capture_queue_empty", cap_q_a.size(), 0);
    chk("a_done_queue_empty",    done_q_a.size(), 0);
    chk("b_capture_queue_empty", cap_q_b.size(), 0);
    chk("b_done_queue_empty",    done_q_b.size(), 0);
    chk("a_done_pulse_count",    done_cnt_a, exp_done_a);
    chk("b_done_pulse_count",    done_cnt_b, exp_done_b);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_seq_fsm.md
GATE_SEQ_FSM -- requirements
Module: gate_seq_fsm

Interface
REQ-001 SHALL have parameter N, default 2: qubit count; vector length L=2**N, gate size L x L.
REQ-002 SHALL have parameter SETTLE, default 1, legal 1..15: cycles allowed for the combinational multiplier to settle.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port init_valid  input  1  initial state vector offered.
REQ-006 SHALL have port init_ready  output  1  block accepts an initial vector.
REQ-007 SHALL have port init_state  input  complexNum[L]  initial vector, Q2.14 per field.
REQ-008 SHALL have port gate_valid  input  1  gate matrix offered.
REQ-009 SHALL have port gate_ready  output  1  block accepts a gate.
REQ-010 SHALL have port gate_last  input  1  qualifies gate_valid; marks final gate of the sequence.
REQ-011 SHALL have port gate_in  input  complexNum[L][L]  gate matrix.
REQ-012 SHALL have port mult_state  output  complexNum[L]  held vector, driven to the downstream multiplier.
REQ-013 SHALL have port mult_gate  output  complexNum[L][L]  held gate, driven to the multiplier.
REQ-014 SHALL have port mult_result  input  complexNum[L]  multiplier product vector.
REQ-015 SHALL have port out_state  output  complexNum[L]  current vector (same register as mult_state).
REQ-016 SHALL have port busy  output  1  high in APPLY.
REQ-017 SHALL have port done  output  1  one-cycle pulse: sequence complete, out_state final.

Function
REQ-018 SHALL implement states IDLE, READY, APPLY, DONE.
REQ-019 SHALL assert init_ready only in IDLE and gate_ready only in READY.
REQ-020 SHALL, in IDLE with init_valid=1, load state_reg from init_state (a and b fields) and enter READY.
REQ-021 SHALL, in READY with gate_valid=1, load gate_reg from gate_in, latch gate_last, clear settle counter and enter APPLY.
REQ-022 SHALL ignore gate_valid outside READY and init_valid outside IDLE; no register changes.
REQ-023 SHALL, in APPLY, increment the settle counter each cycle and on the edge where counter == SETTLE-1 write mult_result (both fields) into state_reg.
REQ-024 SHALL, on that capture edge, enter DONE if latched last=1, else READY.
REQ-025 SHALL thereby give latency: gate accepted at edge E0, updated out_state visible after edge E0+SETTLE.
REQ-026 SHALL, in DONE, assert done for exactly one cycle, hold state_reg, then enter IDLE.
REQ-027 SHALL hold state_reg and gate_reg constant in all states except load and capture edges.
REQ-028 SHALL perform no arithmetic on vector data; fields are stored and forwarded bit-exact.
REQ-029 SHALL support back-to-back gates: one gate per SETTLE+1 cycles maximum throughput.

Reset
REQ-030 SHALL, when reset=1 at a clock edge, enter IDLE, clear state_reg, gate_reg, settle counter and latched last to zero, regardless of current state.
REQ-031 SHALL drive after reset: init_ready=1, gate_ready=0, busy=0, done=0, out_state/mult_state/mult_gate all zero.
REQ-032 SHALL discard an in-flight gate when reset asserts in APPLY; no capture occurs on that edge.

Configuration
REQ-033 SHALL, when macro GATE_SEQ_COUNT_EN is defined, add output gate_count (16 bits): number of captures since the last init load, cleared by reset and by init load, saturating at 16'hFFFF.
REQ-034 SHALL, without GATE_SEQ_COUNT_EN, omit gate_count entirely; all other behaviour identical.

Verification
REQ-035 SHALL cover: reset, load init [4000,0,0,0], identity gate (diagonal 16'h4000), last=1, SETTLE=1 -> out_state unchanged, done pulse one cycle after acceptance edge.
REQ-036 SHALL cover: init [4000,0,0,0], two gates each the permutation 0->1,1->0,2->3,3->2, second with last=1 -> after first capture out_state=[0,4000,0,0], after second [4000,0,0,0], one done pulse.
REQ-037 SHALL cover: SETTLE=3, mult_result forced 16'h1234 only on the third APPLY cycle -> state_reg captures 16'h1234; earlier values never captured.
REQ-038 SHALL cover: gate_valid held high in IDLE and APPLY, init_valid held high in READY -> no register change, handshakes only in legal states.
REQ-039 SHALL cover: reset asserted on second APPLY cycle with SETTLE=3 -> next cycle IDLE, out_state zero, done never pulses.
REQ-040 SHALL cover (GATE_SEQ_COUNT_EN defined): five gates, last on fifth -> gate_count=5 at done; new init load -> gate_count=0.
